// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding and a 2**AW-entry event FIFO.
// Optional typematic repeat suppression is compiled in with `define PS2_REPEAT_FILTER_EN.
module ps2_kbd_rx #(
    parameter int AW          = 3,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             nextdata_n,
    output logic [7:0]       data,
    output logic             ext,
    output logic             brk,
    output logic             ready,
    output logic             overflow,
    output logic [AW:0]      level,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   ext_pend_q, brk_pend_q;
    logic [ERR_W-1:0]       err_cnt_q;
    logic                   overflow_q;
    logic [AW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [9:0]             mem_q [DEPTH];

    logic       sample, data_bit, frame_done, frame_ok, timeout;
    logic       is_prefix, push_req, repeat_hit, push, pop, full, empty, do_write;
    logic [7:0] code;

    // Data is taken from the oldest stage; it is stable for half a PS/2 period around the edge.
    assign sample     = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    assign data_bit   = data_sync_q[SYNC_STAGES-1];
    assign code       = shift_q[8:1];
    assign frame_done = sample && (bit_cnt_q == 4'd10);
    assign frame_ok   = frame_done && !shift_q[0] && data_bit && (^shift_q[9:1]);
    assign timeout    = (bit_cnt_q != 4'd0) && !sample && (to_cnt_q == TW'(TIMEOUT_CYC));
    assign is_prefix  = (code == 8'hE0) || (code == 8'hF0);
    assign push_req   = frame_ok && !is_prefix;

`ifdef PS2_REPEAT_FILTER_EN
    logic       last_valid_q, last_ext_q;
    logic [7:0] last_code_q;

    assign repeat_hit = last_valid_q && !brk_pend_q && (last_ext_q == ext_pend_q) && (last_code_q == code);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_valid_q <= 1'b0;
            last_ext_q   <= 1'b0;
            last_code_q  <= 8'h00;
        end else if (push_req) begin
            if (brk_pend_q) begin
                last_valid_q <= 1'b0;
            end else if (!repeat_hit) begin
                last_valid_q <= 1'b1;
                last_ext_q   <= ext_pend_q;
                last_code_q  <= code;
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign push     = push_req && !repeat_hit;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop      = !empty && !nextdata_n;
    assign do_write = push && (!full || pop);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q + 1'b1;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        if (timeout)
            bit_cnt_d = 4'd0;
        else if (sample)
            bit_cnt_d = (bit_cnt_q == 4'd10) ? 4'd0 : bit_cnt_q + 4'd1;
        if (sample || timeout || bit_cnt_q == 4'd0)
            to_cnt_d = '0;
        if (do_write)
            wptr_d = wptr_q + 1'b1;
        if (pop)
            rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 10'd0;
            to_cnt_q    <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            err_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            if (sample)
                shift_q <= {data_bit, shift_q[9:1]};
            if (((frame_done && !frame_ok) || timeout) && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + 1'b1;
            if (push && full && !pop)
                overflow_q <= 1'b1;
            // Any completed frame or abort settles the prefix state; only a good prefix sets a flag.
            if (timeout || (frame_done && !frame_ok) || push_req) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (frame_ok && code == 8'hE0) begin
                ext_pend_q <= 1'b1;
            end else if (frame_ok && code == 8'hF0) begin
                brk_pend_q <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn)
                mem_q[gi] <= 10'd0;
            else if (do_write && wptr_q[AW-1:0] == AW'(gi))
                mem_q[gi] <= {ext_pend_q, brk_pend_q, code};
        end
    end

    assign {ext, brk, data} = mem_q[rptr_q[AW-1:0]];
    assign ready    = !empty;
    assign level    = wptr_q - rptr_q;
    assign overflow = overflow_q;
    assign err_cnt  = err_cnt_q;
endmodule
